uart_byte_rx: RTL and testbench

Synthesisable UART receiver that consumes the serial stream the system drives on `usb_uart_txd` and turns it into bytes behind a valid/ready handshake. It decodes 8N1 frames and buffers them in a small FIFO. It reports framing errors and FIFO overflow as single-cycle pulses. It sits directly downstream of the system top wrapper's UART transmit pin, both on the Arty bench and as a loopback/console sink in on-board debug builds.

---
 rtl/uart_byte_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver feeding a small byte FIFO.
// Framing errors and dropped bytes are flagged as one-cycle pulses.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sys_clock,
  input  logic       resetn,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic          rxd_m;
  logic          rxd_s;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          push;
  logic          ferr;
  logic          push_q;
  logic          ferr_q;
  logic [7:0]    byte_q;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          full;
  logic          pop;
  logic          wr_en;

  // two-flop synchroniser, idles high
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  // frame decoder state and datapath registers
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // next-state: mid-bit sampling driven by the bit timer
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd_s) begin
          bit_cnt_n = HALF_LD;
          state_n   = START;
        end
      end
      START: begin
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - 1'b1;
        end else if (!rxd_s) begin
          bit_cnt_n = BIT_LD;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - 1'b1;
        end else begin
          shreg_n   = {rxd_s, shreg[7:1]};
          bit_cnt_n = BIT_LD;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - 1'b1;
        end else if (rxd_s) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          ferr    = 1'b1;
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // stage the completed frame one cycle ahead of the FIFO
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      byte_q <= '0;
    end else begin
      push_q <= push;
      ferr_q <= ferr;
      if (push) begin
        byte_q <= shreg;
      end
    end
  end

  assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = (wr_ptr != rd_ptr);
  assign pop      = rx_valid && rx_ready;
  assign wr_en    = push_q && (!full || pop);
  assign rx_data  = mem[rd_ptr[AW-1:0]];

  // FIFO storage and pointers; a pop frees the slot a full push reuses
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= byte_q;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // status pulses, aligned with the byte landing in the FIFO
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ferr_q;
      overflow  <= push_q && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed frames against a sample-point model.
// Model predicts bytes, FIFO contents and pulses per cycle.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int C = 16;
  localparam int D = 4;
  localparam int FR = 10 * C;

  logic       sys_clock = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;

  uart_byte_rx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .sys_clock(sys_clock),
    .resetn   (resetn),
    .uart_rxd (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 sys_clock = ~sys_clock;

  int total = 0;
  int bad   = 0;
  int cyc   = -1;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int vcnt     = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // model: line history judged at the nominal sample instants
  logic [7:0] q[$];
  int         mode = 0;
  int         avail = 0;
  int         m_t0 = 0;
  logic [7:0] bytev = '0;
  int         ev_t = -1;
  logic       ev_push = 1'b0;
  logic [7:0] ev_byte = '0;
  logic       m_ferr = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge sys_clock) begin
    int d;
    int k;
    cyc = cyc + 1;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    if (!resetn) begin
      q.delete();
      ev_t  = -1;
      mode  = 0;
      avail = cyc + 1;
    end else begin
      if (q.size() != 0 && rx_ready) begin
        void'(q.pop_front());
      end
      if (ev_t == cyc) begin
        if (!ev_push) m_ferr = 1'b1;
        else if (q.size() < D) q.push_back(ev_byte);
        else m_ovf = 1'b1;
      end
      if (mode == 0) begin
        if (cyc >= avail && uart_rxd == 1'b0) begin
          m_t0 = cyc;
          mode = 1;
        end
      end else if (mode == 1) begin
        d = cyc - m_t0 - C / 2;
        if (d == 0 && uart_rxd) begin
          mode  = 0;
          avail = cyc + 1;
        end else if (d > 0 && d % C == 0) begin
          k = d / C;
          if (k <= 8) begin
            bytev[k-1] = uart_rxd;
          end else begin
            ev_t    = cyc + 3;
            ev_push = uart_rxd;
            ev_byte = bytev;
            if (uart_rxd) begin
              mode  = 0;
              avail = cyc + 1;
            end else begin
              mode = 2;
            end
          end
        end
      end else begin
        if (uart_rxd) begin
          mode  = 0;
          avail = cyc + 1;
        end
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge sys_clock) begin
    if (cyc >= 0) begin
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (rx_valid) vcnt++;
      if (!resetn) begin
        chk("rst valid", 32'(rx_valid), 0);
        chk("rst data", 32'(rx_data), 0);
        chk("rst ferr", 32'(frame_err), 0);
        chk("rst ovf", 32'(overflow), 0);
      end else begin
        chk("valid", 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("data", 32'(rx_data), 32'(q[0]));
        chk("ferr", 32'(frame_err), 32'(m_ferr));
        chk("ovf", 32'(overflow), 32'(m_ovf));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) uart_rxd = 1'b0;
      else if (i == 9) uart_rxd = stop;
      else uart_rxd = b[i-1];
      repeat (C) @(negedge sys_clock);
    end
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge sys_clock);
  endtask

  task automatic drain(input logic [31:0] b0, input logic [31:0] b1,
                       input logic [31:0] b2, input logic [31:0] b3);
    logic [31:0] e [4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain valid", 32'(rx_valid), 1);
      chk("drain data", 32'(rx_data), e[i]);
      @(negedge sys_clock);
    end
    chk("drain empty", 32'(rx_valid), 0);
    rx_ready = 1'b0;
  endtask

  task automatic one_byte(input logic [7:0] b, input string nm);
    int t0;
    t0 = cyc + 1;
    fork
      send(b, 1'b1);
      begin
        at_cycle(t0 + 154);
        chk({nm, " early"}, 32'(rx_valid), 0);
        at_cycle(t0 + 155);
        chk({nm, " valid"}, 32'(rx_valid), 1);
        chk({nm, " data"}, 32'(rx_data), 32'(b));
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int f0;
    int v0;
    int o0;
    resetn   = 1'b0;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge sys_clock);
    @(posedge sys_clock);
    #2 resetn = 1'b1;
    repeat (5) @(negedge sys_clock);

    // single byte, consumed immediately
    rx_ready = 1'b1;
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    t0 = cyc + 1;
    fork
      send(8'h55, 1'b1);
      begin
        at_cycle(t0 + 154);
        chk("t1 pre", 32'(rx_valid), 0);
        at_cycle(t0 + 155);
        chk("t1 valid", 32'(rx_valid), 1);
        chk("t1 data", 32'(rx_data), 32'h55);
        at_cycle(t0 + 156);
        chk("t1 post", 32'(rx_valid), 0);
      end
    join
    repeat (10) @(negedge sys_clock);
    chk("t1 nferr", ferr_cnt - f0, 0);
    chk("t1 novf", ovf_cnt - o0, 0);

    // short start glitch is ignored
    f0 = ferr_cnt;
    v0 = vcnt;
    uart_rxd = 1'b0;
    repeat (4) @(negedge sys_clock);
    uart_rxd = 1'b1;
    repeat (40) @(negedge sys_clock);
    chk("t2 nvalid", vcnt - v0, 0);
    chk("t2 nferr", ferr_cnt - f0, 0);
    one_byte(8'hA3, "t2");
    repeat (10) @(negedge sys_clock);

    // framing error followed by a held-low line
    f0 = ferr_cnt;
    v0 = vcnt;
    t0 = cyc + 1;
    fork
      send(8'hA3, 1'b0);
      begin
        at_cycle(t0 + 154);
        chk("t3 pre", 32'(frame_err), 0);
        at_cycle(t0 + 155);
        chk("t3 ferr", 32'(frame_err), 1);
        chk("t3 nvalid", 32'(rx_valid), 0);
        at_cycle(t0 + 156);
        chk("t3 post", 32'(frame_err), 0);
      end
    join
    uart_rxd = 1'b0;
    repeat (3 * C) @(negedge sys_clock);
    uart_rxd = 1'b1;
    repeat (2 * C) @(negedge sys_clock);
    chk("t3 once", ferr_cnt - f0, 1);
    chk("t3 empty", vcnt - v0, 0);
    one_byte(8'h3C, "t3");
    repeat (10) @(negedge sys_clock);

    // overflow on the fifth back-to-back byte
    rx_ready = 1'b0;
    o0 = ovf_cnt;
    t0 = cyc + 1;
    fork
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      begin
        at_cycle(t0 + 4 * FR + 155);
        chk("t4 ovf", 32'(overflow), 1);
      end
    join
    repeat (10) @(negedge sys_clock);
    chk("t4 once", ovf_cnt - o0, 1);
    drain(32'h01, 32'h02, 32'h03, 32'h04);
    repeat (10) @(negedge sys_clock);

    // full FIFO with a pop on the push cycle
    o0 = ovf_cnt;
    t0 = cyc + 1;
    fork
      begin
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'h04, 1'b1);
        send(8'h77, 1'b1);
      end
      begin
        at_cycle(t0 + 4 * FR + 154);
        rx_ready = 1'b1;
        @(negedge sys_clock);
        rx_ready = 1'b0;
        chk("t5 ovf", 32'(overflow), 0);
        chk("t5 head", 32'(rx_data), 32'h02);
      end
    join
    repeat (10) @(negedge sys_clock);
    chk("t5 novf", ovf_cnt - o0, 0);
    drain(32'h02, 32'h03, 32'h04, 32'h77);
    repeat (10) @(negedge sys_clock);

    // reset mid-frame clears a held byte and the partial frame
    send(8'h5A, 1'b1);
    repeat (5) @(negedge sys_clock);
    t0 = cyc + 1;
    fork
      send(8'hF0, 1'b1);
      begin
        at_cycle(t0 + 84);
        chk("t6 held", 32'(rx_data), 32'h5A);
        @(posedge sys_clock);
        #2 resetn = 1'b0;
        #1;
        chk("t6 valid", 32'(rx_valid), 0);
        chk("t6 data", 32'(rx_data), 0);
        chk("t6 ferr", 32'(frame_err), 0);
        chk("t6 ovf", 32'(overflow), 0);
        repeat (3) @(posedge sys_clock);
        #2 resetn = 1'b1;
      end
    join
    repeat (10) @(negedge sys_clock);
    rx_ready = 1'b1;
    one_byte(8'h0F, "t6");
    repeat (10) @(negedge sys_clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
